// File: rtl/ext_unit_dispatcher.sv
// Dispatches one multi-cycle request from the main FSM to one of NUM_UNITS execution units.
// The result is registered, and the request is aborted on timeout, flush or an out-of-range unit index.
module ext_unit_dispatcher #(
  parameter int NUM_UNITS      = 2,
  parameter int UNIT_ID_WIDTH  = 2,
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      req_valid,
  input  logic [UNIT_ID_WIDTH-1:0]  req_unit,
  input  logic                      flush,
  output logic                      req_ready,
  output logic [XLEN-1:0]           result,
  output logic                      busy,
  output logic                      timeout_event,
  output logic                      illegal_unit,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [NUM_UNITS-1:0]      unit_valid,
  input  logic [NUM_UNITS-1:0]      unit_ready,
  input  logic [NUM_UNITS*XLEN-1:0] unit_result,
  output logic [1:0]                dbg_state
);

  // Handshake: a request is taken when req_valid is high in IDLE without flush. Completion is a
  // single-cycle req_ready with result valid in that cycle. unit_valid stays high until the unit's ready.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  state_t                   state_q, state_d;
  logic [UNIT_ID_WIDTH-1:0] unit_id_q, unit_id_d;
  logic [NUM_UNITS-1:0]     unit_valid_q, unit_valid_d;
  logic [XLEN-1:0]          result_q, result_d;
  logic                     req_ready_q, req_ready_d;
  logic                     timeout_q, timeout_d;
  logic                     illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0]     stall_q, stall_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

  logic                     req_legal;
  logic [NUM_UNITS-1:0]     req_onehot;
  logic                     sel_ready;
  logic [XLEN-1:0]          sel_data;

  always_comb begin
    req_legal  = (32'(req_unit) < NUM_UNITS);
    req_onehot = '0;
    sel_ready  = 1'b0;
    sel_data   = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      req_onehot[i] = (req_unit == UNIT_ID_WIDTH'(i));
      if (unit_id_q == UNIT_ID_WIDTH'(i)) begin
        sel_ready = unit_ready[i];
        sel_data  = unit_result[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    unit_id_d    = unit_id_q;
    unit_valid_d = unit_valid_q;
    result_d     = result_q;
    req_ready_d  = 1'b0;
    timeout_d    = 1'b0;
    illegal_d    = 1'b0;
    cnt_d        = cnt_q;
    stall_d      = stall_q;

    if (flush) begin
      state_d      = ST_IDLE;
      unit_valid_d = '0;
      cnt_d        = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (req_valid) begin
            unit_id_d = req_unit;
            if (req_legal) begin
              state_d      = ST_BUSY;
              unit_valid_d = req_onehot;
            end else begin
              state_d     = ST_DONE;
              result_d    = '0;
              req_ready_d = 1'b1;
              illegal_d   = 1'b1;
            end
          end
        end
        ST_BUSY: begin
          cnt_d = cnt_q + 1'b1;
          // A ready arriving on the last allowed cycle still completes normally.
          if (sel_ready) begin
            state_d      = ST_DONE;
            result_d     = sel_data;
            unit_valid_d = '0;
            req_ready_d  = 1'b1;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
            state_d      = ST_DONE;
            result_d     = '0;
            unit_valid_d = '0;
            req_ready_d  = 1'b1;
            timeout_d    = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d      = ST_IDLE;
          unit_valid_d = '0;
          cnt_d        = '0;
        end
      endcase
    end

    // Every cycle spent in BUSY is a stall cycle, including one cut short by flush.
    if ((state_q == ST_BUSY) && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      unit_id_q    <= '0;
      unit_valid_q <= '0;
      result_q     <= '0;
      req_ready_q  <= 1'b0;
      timeout_q    <= 1'b0;
      illegal_q    <= 1'b0;
      stall_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      unit_id_q    <= unit_id_d;
      unit_valid_q <= unit_valid_d;
      result_q     <= result_d;
      req_ready_q  <= req_ready_d;
      timeout_q    <= timeout_d;
      illegal_q    <= illegal_d;
      stall_q      <= stall_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign result        = result_q;
  assign busy          = (state_q != ST_IDLE);
  assign timeout_event = timeout_q;
  assign illegal_unit  = illegal_q;
  assign stall_cycles  = stall_q;
  assign unit_valid    = unit_valid_q;
  assign dbg_state     = state_q;

endmodule
